color_sequencer: RTL and testbench

Parametrised successor to the fixed RGB colour-step decoder. Generates R/G/B PWM duty values from an N-entry palette, paced by an internal tick prescaler. The mode is selected by sw: step, hold, fade (linear ramp between entries) or blank. It sits between the switch inputs and the three per-channel PWM generators, which consume the *_time_out values.

---
 rtl/color_sequencer_pkg.sv | 17 +
 rtl/color_fade_channel.sv | 22 ++
 rtl/color_sequencer.sv | 94 +++++++++
 tb/tb_color_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/color_sequencer_pkg.sv
// color_seq_pkg: shared mode/state types, palette table and channel scaling helpers.
package color_seq_pkg;
  typedef enum logic [1:0] {M_STEP, M_HOLD, M_FADE, M_BLANK} mode_t;
  typedef enum logic [2:0] {S_IDLE, S_STEP, S_HOLD, S_FADE, S_BLANK} state_t;
  localparam logic [23:0] PALETTE [16] = '{
    24'hFF0000, 24'hFF6100, 24'hFFFF00, 24'h00FF00,
    24'h0000FF, 24'h082E54, 24'hA020F0, 24'hFFFFFF,
    24'h00FFFF, 24'hFF00FF, 24'hFF69B4, 24'h008080,
    24'h80FF00, 24'h000080, 24'h808080, 24'h404040
  };
  function automatic logic [31:0] pal_scale(input logic [7:0] p, input int w);
    return w >= 8 ? {24'd0, p} << (w - 8) : {24'd0, p} >> (8 - w);
  endfunction
  function automatic state_t st_of(input mode_t m);
    return m == M_STEP ? S_STEP : m == M_HOLD ? S_HOLD : m == M_FADE ? S_FADE : S_BLANK;
  endfunction
endpackage

// File: rtl/color_fade_channel.sv
// color_fade_channel: next duty value for one channel (blank, load, or clamped ramp toward target).
module color_fade_channel #(
  parameter int W = 8
)(
  input  logic [W-1:0] current,
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  input  logic         load,
  input  logic         fade_en,
  input  logic         blank,
  output logic [W-1:0] nxt,
  output logic         at_target
);
  logic signed [W:0] d, s;
  assign at_target = current == target;
  always_comb begin
    d = $signed({1'b0, target}) - $signed({1'b0, current});
    s = $signed({1'b0, step});
    nxt = blank ? '0 : load ? target : !fade_en ? current :
          d > s ? current + step : d < -s ? current - step : target;
  end
endmodule

// File: rtl/color_sequencer.sv
// color_sequencer: palette-driven RGB duty sequencer with step/hold/fade/blank modes and tick prescaler.
module color_sequencer
  import color_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 7,
  parameter int DIV = 1000,
  parameter int DWELL = 4,
  parameter int STEP = 1,
  localparam int IW = N > 1 ? $clog2(N) : 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    sw,
  output logic [W-1:0]  R_time_out,
  output logic [W-1:0]  G_time_out,
  output logic [W-1:0]  B_time_out,
  output logic [IW-1:0] color_idx,
  output logic          seq_wrap
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DWELL + 1);
  logic [1:0] s1, s2;
  mode_t mode;
  state_t state, state_n, cur_st;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dwell, dwell_n, deff;
  logic [W-1:0] ch [3], nv [3], tgt [3];
  logic [2:0] at;
  logic [IW-1:0] nidx, tidx;
  logic tick, idle, change, last, is_step, is_fade, step_adv, fade_adv, adv;
  logic load, fade_en, blank, all_at;
  assign R_time_out = ch[0];
  assign G_time_out = ch[1];
  assign B_time_out = ch[2];
  always_comb begin
    tick = cnt == CW'(DIV - 1);
    idle = state == S_IDLE;
    cur_st = st_of(mode);
    change = !idle && state != cur_st;
    deff = change ? '0 : dwell;
    last = deff == DW'(DWELL - 1);
    is_step = !idle && mode == M_STEP;
    is_fade = !idle && mode == M_FADE;
    step_adv = is_step && tick && last;
    nidx = color_idx == IW'(N - 1) ? '0 : color_idx + 1'b1;
    tidx = idle ? '0 : step_adv ? nidx : color_idx;
    load = tick && (idle || is_step);
    blank = !idle && mode == M_BLANK;
    state_n = idle && !tick ? S_IDLE : cur_st;
  end
  // Fade advance and dwell depend on at_target, kept apart from the target-select path.
  always_comb begin
    all_at = &at;
    fade_adv = is_fade && tick && all_at && last;
    adv = step_adv || fade_adv;
    fade_en = is_fade && tick && !all_at;
    dwell_n = tick && (is_step || (is_fade && all_at)) ? (last ? '0 : deff + 1'b1) :
              !tick && (is_step || is_fade) ? deff : '0;
  end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign tgt[i] = W'(pal_scale(PALETTE[tidx][23-8*i -: 8], W));
    color_fade_channel #(.W(W)) u_ch (
      .current(ch[i]), .target(tgt[i]), .step(W'(STEP)), .load(load),
      .fade_en(fade_en), .blank(blank), .nxt(nv[i]), .at_target(at[i])
    );
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_n;
  end
  // sw is asynchronous: two synchroniser flops, then the registered mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      mode <= M_STEP;
      cnt <= '0;
      dwell <= '0;
      color_idx <= '0;
      seq_wrap <= 1'b0;
      ch <= '{'0, '0, '0};
    end else begin
      s1 <= sw;
      s2 <= s1;
      mode <= mode_t'(s2);
      cnt <= tick ? '0 : cnt + 1'b1;
      dwell <= dwell_n;
      color_idx <= adv ? nidx : color_idx;
      seq_wrap <= adv && color_idx == IW'(N - 1);
      ch <= nv;
    end
  end
endmodule

// File: tb/tb_color_sequencer.sv
// tb_color_sequencer: randomized mode sequences checked by a scoreboard against a palette-level reference model.
module tb_color_sequencer;
  localparam int W = 8, N = 7, DIV = 2, DWELL = 2, STEP = 64;
  logic clk = 0, rst = 0;
  logic [1:0] sw = 0;
  logic [W-1:0] r, g, b;
  logic [2:0] idx;
  logic wrap;
  color_sequencer #(.W(W), .N(N), .DIV(DIV), .DWELL(DWELL), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .sw(sw), .R_time_out(r), .G_time_out(g), .B_time_out(b),
    .color_idx(idx), .seq_wrap(wrap)
  );
  always #5 clk = ~clk;
  typedef struct {int r; int g; int b; int idx; int wrap;} exp_t;
  exp_t q[$];
  int pal [7][3] = '{'{255,0,0}, '{255,97,0}, '{255,255,0}, '{0,255,0}, '{0,0,255}, '{8,46,84}, '{160,32,240}};
  int tests = 0, fails = 0;
  bit mon = 0;
  int mr, mg, mb, midx, mwrap, mdw, mpm, mc;
  bit started;
  int hist[$];
  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction
  task automatic model_reset();
    mr = 0; mg = 0; mb = 0; midx = 0; mwrap = 0; mdw = 0; mpm = 0; mc = 0;
    started = 0;
    hist = '{0, 0, 0};
  endtask
  function automatic int toward(int cur, int tgt);
    if (tgt - cur > STEP) return cur + STEP;
    if (tgt - cur < -STEP) return cur - STEP;
    return tgt;
  endfunction
  task automatic show(int i);
    mr = pal[i][0]; mg = pal[i][1]; mb = pal[i][2];
  endtask
  // Mode seen by the sequencer lags sw by three clocks.
  task automatic model_edge(int s);
    int m;
    bit tk, here;
    m = hist.pop_front();
    hist.push_back(s);
    tk = (mc % DIV) == DIV - 1;
    mc++;
    mwrap = 0;
    if (!started) begin
      if (tk) begin
        show(0);
        started = 1;
        mpm = m;
      end
      return;
    end
    if (m != mpm) mdw = 0;
    mpm = m;
    here = mr == pal[midx][0] && mg == pal[midx][1] && mb == pal[midx][2];
    if (m == 3) begin
      mr = 0; mg = 0; mb = 0; mdw = 0;
    end else if (m == 1) mdw = 0;
    else if (tk) begin
      if (m == 2 && !here) begin
        mr = toward(mr, pal[midx][0]);
        mg = toward(mg, pal[midx][1]);
        mb = toward(mb, pal[midx][2]);
        mdw = 0;
      end else if (mdw == DWELL - 1) begin
        mwrap = midx == N - 1;
        midx = (midx + 1) % N;
        mdw = 0;
        if (m == 0) show(midx);
      end else begin
        mdw++;
        if (m == 0) show(midx);
      end
    end
  endtask
  task automatic push();
    exp_t e;
    e = '{mr, mg, mb, midx, mwrap};
    q.push_back(e);
  endtask
  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge(sw);
    else model_reset();
    push();
    mon = 1;
    #1;
  endtask
  task automatic direct_zero(string tag);
    check({tag, "_R"}, r, 0);
    check({tag, "_G"}, g, 0);
    check({tag, "_B"}, b, 0);
    check({tag, "_idx"}, idx, 0);
    check({tag, "_wrap"}, wrap, 0);
  endtask
  task automatic do_reset();
    rst = 0;
    model_reset();
    q.delete();
    push();
    #1;
    direct_zero("async_rst");
    repeat (3) cycle();
    rst = 1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: queue empty, need 1 entry at %0t", $time);
        end else begin
          e = q.pop_front();
          check("R", r, e.r);
          check("G", g, e.g);
          check("B", b, e.b);
          check("idx", idx, e.idx);
          check("wrap", wrap, e.wrap);
        end
      end
    end
  end
  initial begin
    int pm [10] = '{0, 1, 2, 3, 0, 2, 1, 0, 3, 2};
    int pl [10] = '{100, 200, 150, 20, 40, 60, 30, 60, 10, 80};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    direct_zero("reset");
    rst = 1;
    foreach (pm[i]) begin
      sw = 2'(pm[i]);
      repeat (pl[i]) cycle();
    end
    for (int s = 0; s < 40; s++) begin
      if (s == 20) begin
        sw = 2'd2;
        repeat (13) cycle();
        do_reset();
      end
      sw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : $urandom_range(10, 150)) cycle();
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
